// File: rtl/conv_row_scheduler.sv
// conv_row_scheduler: walks KERNELxKERNEL windows over an IMG_SIZE map, driving the row buffer and window stream.
// Optional LB_TIMEOUT_EN macro adds a WAIT watchdog that pulses err after TIMEOUT_CYC cycles.
module conv_row_scheduler #(
  parameter int IMG_SIZE    = 28,
  parameter int KERNEL      = 3,
  parameter int ROW_W       = 5,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             lb_start,
  output logic [ROW_W-1:0] lb_row,
  input  logic             lb_done,
  output logic             lb_shift_en,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [ROW_W-1:0] win_row,
  output logic [ROW_W-1:0] win_col,
  output logic             busy,
  output logic             frame_done,
  output logic             err
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, PRIME, WIN, NEXT, DONE} state_t;
  localparam logic [ROW_W-1:0] LAST = ROW_W'(IMG_SIZE - KERNEL);
  localparam int PW = $clog2(KERNEL + 1);
  localparam logic [PW-1:0] PLAST = PW'(KERNEL - 1);
  state_t st;
  logic [ROW_W-1:0] row, col;
  logic [PW-1:0] pcnt;
  logic tout;
`ifdef LB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  assign tout = st == WAIT && !lb_done && tcnt == TW'(TIMEOUT_CYC - 1);
  // tcnt sits at zero outside WAIT, so it restarts on every WAIT entry
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      tcnt <= st == WAIT ? tcnt + 1'b1 : '0;
      err  <= tout && !abort;
    end
`else
  assign tout = 1'b0;
  assign err  = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st   <= IDLE;
      row  <= '0;
      col  <= '0;
      pcnt <= '0;
    end else if (abort) begin
      st   <= IDLE;
      row  <= '0;
      col  <= '0;
      pcnt <= '0;
    end else begin
      case (st)
        IDLE: if (start) st <= LOAD;
        LOAD: st <= WAIT;
        WAIT:
          if (lb_done) begin
            st   <= PRIME;
            col  <= '0;
            pcnt <= '0;
          end else if (tout) begin
            st  <= IDLE;
            row <= '0;
            col <= '0;
          end
        PRIME: begin
          pcnt <= pcnt + 1'b1;
          if (pcnt == PLAST) begin
            st  <= WIN;
            col <= '0;
          end
        end
        WIN:
          if (win_ready) begin
            if (col == LAST) st <= NEXT;
            else col <= col + 1'b1;
          end
        NEXT:
          if (row == LAST) st <= DONE;
          else begin
            row <= row + 1'b1;
            st  <= LOAD;
          end
        DONE: begin
          st  <= IDLE;
          row <= '0;
          col <= '0;
        end
        default: st <= IDLE;
      endcase
    end
  assign lb_start    = st == LOAD;
  assign lb_row      = row;
  // stepping shifts ride the handshake combinationally; the last column of a row does not shift
  assign lb_shift_en = st == PRIME || (st == WIN && win_ready && col != LAST);
  assign win_valid   = st == WIN;
  assign win_row     = row;
  assign win_col     = col;
  assign busy        = st != IDLE;
  assign frame_done  = st == DONE;
endmodule

// File: doc/conv_row_scheduler.md
# conv_row_scheduler

- Sequences the three-row load buffer across one IMG_SIZE x IMG_SIZE feature map for KERNEL x KERNEL convolution.
- For each window row: drives the buffer's row number, starts a load, waits for the buffer's done, primes its shift registers, then steps one column per window accepted downstream.
- Sits between the layer controller (start/frame_done) and the load buffer plus MAC array (valid/ready window stream).

## Interface
Parameters:
- IMG_SIZE, 28, feature-map width and height in pixels
- KERNEL, 3, window size; rows loaded per window row
- ROW_W, 5, width of row/column indices; must satisfy 2^ROW_W > IMG_SIZE
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with LB_TIMEOUT_EN

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  frame start pulse; sampled in IDLE only
- abort  in  1  synchronous abort; highest priority
- lb_start  out  1  one-cycle load request to the buffer
- lb_row  out  ROW_W  top image row of the current window row
- lb_done  in  1  buffer load complete; sampled in WAIT only
- lb_shift_en  out  1  shift buffer one column
- win_valid  out  1  window available to the MAC array
- win_ready  in  1  MAC array accepts the window
- win_row, win_col  out  ROW_W each  top-left coordinate of the presented window
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse after the last window is accepted
- err  out  1  one-cycle pulse on watchdog timeout

## Operation
- States: IDLE, LOAD, WAIT, PRIME, WIN, NEXT, DONE. State, row and column counters are registered. Outputs are decoded from state and counters.
- IDLE: row=0, col=0. On start, go to LOAD.
- LOAD: lb_start=1 for exactly one cycle. lb_row=row. Next state is WAIT.
- WAIT: hold lb_row and wait for lb_done=1, then go to PRIME with col=0.
- PRIME: lb_shift_en=1 for KERNEL consecutive cycles. After the KERNEL-th shift, go to WIN with col=0.
- WIN: win_valid=1, win_row=row, win_col=col.
  - On win_valid && win_ready with col < IMG_SIZE-KERNEL: lb_shift_en=1 in that same cycle and col increments.
  - On a handshake with col = IMG_SIZE-KERNEL: no shift; go to NEXT.
  - win_valid holds, and win_row/win_col stay stable, until the handshake completes.
- NEXT: if row = IMG_SIZE-KERNEL, go to DONE. Otherwise row increments and the state goes to LOAD.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- Counts: IMG_SIZE-KERNEL+1 window rows per frame and the same number of windows per row (676 at the defaults). Counters never exceed IMG_SIZE-KERNEL and never wrap.
- abort=1 in any state: next state is IDLE and counters clear. No frame_done pulse. Outputs in the abort cycle follow the current state.
- start outside IDLE is ignored. start and abort together in IDLE: stay in IDLE.
- lb_done outside WAIT is ignored, including an lb_done that arrives in the LOAD cycle.
- Reset values: every output 0, lb_row=0, win_row=0, win_col=0, state IDLE. Reset asserted mid-frame aborts immediately and asynchronously.

## Timing
- start high at cycle 0 → lb_start high at cycle 1 → WAIT from cycle 2.
- lb_done high at cycle t → lb_shift_en high at cycles t+1..t+KERNEL → first win_valid at t+KERNEL+1.
- With win_ready held high, windows are accepted one per cycle. Last handshake of a row at cycle u → NEXT at u+1 → lb_start at u+2.
- Last handshake of the frame at cycle u → frame_done at u+2; busy falls at u+3.
- No combinational path from lb_done to any output. There is a combinational path from win_ready to lb_shift_en, by design.

## Configuration
- Macro: LB_TIMEOUT_EN.
- Defined: a cycle counter clears on entry to WAIT and increments every cycle spent in WAIT. If it reaches TIMEOUT_CYC without lb_done, err pulses one cycle and the state goes to IDLE with no frame_done. If lb_done arrives in the same cycle the limit is hit, lb_done wins and there is no err.
- Undefined: WAIT lasts indefinitely, err is tied to 0, and no counter logic is built.

## Test plan
Configure IMG_SIZE=5, KERNEL=3 unless noted.
- Full frame, win_ready=1, lb_done returned 4 cycles after each lb_start → 3 lb_start pulses with lb_row 0,1,2; 9 windows in row-major (row,col) order (0,0)..(2,2); 3 PRIME shifts plus 2 step shifts per row; one frame_done.
- Backpressure: toggle win_ready randomly → win_row/win_col stable while win_valid && !win_ready; lb_shift_en never high without a handshake in WIN; window sequence identical to the first scenario.
- abort asserted in PRIME of row 1 → IDLE next cycle; no frame_done; a subsequent start restarts at lb_row=0.
- rst pulled low in WIN with win_valid=1 → all outputs 0 immediately; clean frame after release.
- Spurious lb_done during LOAD, and start while busy → both ignored; the scheduler waits for lb_done in WAIT.
- With LB_TIMEOUT_EN and TIMEOUT_CYC=8, lb_done withheld → err pulse 8 cycles after entering WAIT, then IDLE. With lb_done on exactly the 8th cycle → no err and PRIME follows.
